// File: rtl/midi_pkg.sv
// Shared MIDI encoding helpers for the outbound message path.
// Holds status nibble codes, the byte-count decode and the real-time predicate.
package midi_pkg;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] POLY_AT  = 4'hA;
  localparam logic [3:0] CC       = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CH_AT    = 4'hD;
  localparam logic [3:0] PITCH    = 4'hE;
  localparam logic [3:0] SYS      = 4'hF;

  typedef enum logic [1:0] {IDLE, S_STATUS, S_D1, S_D2} tx_state_e;

  // Total bytes on the wire (status included) for a given status byte.
  function automatic logic [1:0] msg_len(input logic [7:0] status);
    logic [1:0] len;
    case (status[7:4])
      NOTE_OFF, NOTE_ON, POLY_AT, CC, PITCH: len = 2'd3;
      PROG, CH_AT:                           len = 2'd2;
      SYS: begin
        case (status[3:0])
          4'h1, 4'h3: len = 2'd2;
          4'h2:       len = 2'd3;
          default:    len = 2'd1;
        endcase
      end
      default: len = 2'd1;
    endcase
    return len;
  endfunction

  function automatic logic is_realtime(input logic [7:0] status);
    return status[7:3] == 5'b11111;
  endfunction

  function automatic logic is_channel(input logic [7:0] status);
    return status[7] && (status[7:4] != SYS);
  endfunction

endpackage

// File: rtl/midi_msg_tx.sv
// MIDI event-to-byte encoder with running-status compression, feeding the
// simpleuart write port one byte at a time.
module midi_msg_tx
  import midi_pkg::*;
#(
  parameter int          RUNNING_STATUS    = 1,
  parameter int unsigned RS_TIMEOUT_CYCLES = 4800000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ev_valid,
  output logic       ev_ready,
  input  logic [7:0] ev_status,
  input  logic [6:0] ev_data1,
  input  logic [6:0] ev_data2,
  output logic       tx_we,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic       drop,
  output logic       idle
);

  localparam logic [31:0] TO = 32'(RS_TIMEOUT_CYCLES);

  tx_state_e   state, state_d;
  logic [7:0]  st_q;
  logic [6:0]  d1_q, d2_q;
  logic [1:0]  len_q;
  logic [7:0]  ls_byte;
  logic        ls_valid;
  logic [31:0] rs_cnt;

  logic        accept, wr_ok, expired, suppress;
  logic [7:0]  cur_st, tx_data_d;
  logic [6:0]  cur_d1, cur_d2;

  assign accept  = ev_valid && ev_ready;
  assign wr_ok   = tx_we && !tx_busy;
  // Expiry is evaluated combinationally so an accept in the same cycle already sees it.
  assign expired = (TO != 32'd0) && (rs_cnt >= TO);
  assign suppress = (RUNNING_STATUS != 0) && is_channel(ev_status) &&
                    ls_valid && !expired && (ev_status == ls_byte);

  assign cur_st = accept ? ev_status : st_q;
  assign cur_d1 = accept ? ev_data1  : d1_q;
  assign cur_d2 = accept ? ev_data2  : d2_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (accept && ev_status[7])
              state_d = suppress ? S_D1 : S_STATUS;
      S_STATUS: if (wr_ok) state_d = (len_q > 2'd1) ? S_D1 : IDLE;
      S_D1:     if (wr_ok) state_d = (len_q == 2'd3) ? S_D2 : IDLE;
      S_D2:     if (wr_ok) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    ev_ready = (state == IDLE);
    idle     = (state == IDLE) && !ev_valid;
  end

  // Byte register is loaded from the state being entered, so the next byte
  // appears the cycle after the previous one is accepted.
  always_comb begin
    tx_data_d = tx_data;
    case (state_d)
      S_STATUS: tx_data_d = cur_st;
      S_D1:     tx_data_d = {1'b0, cur_d1};
      S_D2:     tx_data_d = {1'b0, cur_d2};
      default:  tx_data_d = tx_data;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_we   <= 1'b0;
      tx_data <= 8'h00;
      drop    <= 1'b0;
      st_q    <= 8'h00;
      d1_q    <= 7'h00;
      d2_q    <= 7'h00;
      len_q   <= 2'd1;
    end else begin
      tx_we   <= (state_d != IDLE);
      tx_data <= tx_data_d;
      drop    <= accept && !ev_status[7];
      if (accept) begin
        st_q  <= ev_status;
        d1_q  <= ev_data1;
        d2_q  <= ev_data2;
        len_q <= msg_len(ev_status);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ls_valid <= 1'b0;
      ls_byte  <= 8'h00;
    end else if (state == S_STATUS && wr_ok && is_channel(st_q)) begin
      ls_valid <= 1'b1;
      ls_byte  <= st_q;
    end else if (accept && ev_status[7:4] == SYS && !is_realtime(ev_status)) begin
      ls_valid <= 1'b0;
    end else if (expired) begin
      ls_valid <= 1'b0;
    end
  end

  // Real-time bytes must not refresh the running-status window.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                           rs_cnt <= 32'd0;
    else if (wr_ok && !is_realtime(tx_data)) rs_cnt <= 32'd0;
    else if (rs_cnt != 32'hFFFF_FFFF)      rs_cnt <= rs_cnt + 32'd1;
  end

endmodule

// File: doc/midi_msg_tx.md
Name: midi_msg_tx

Overview:
- Encodes MIDI channel, system-common and real-time events into a MIDI byte stream.
- Applies running-status compression to channel messages.
- Drives the byte-write side of the existing simpleuart: tx_we/tx_data into reg_dat_we/reg_dat_di, tx_busy from tx_busy.
- Sits between the synth's event sources (sequencer, controller logic) and the UART; it is the outbound counterpart to the MIDI input path.

Parameters:
- RUNNING_STATUS, 1: 1 enables running-status suppression; 0 always sends the status byte.
- RS_TIMEOUT_CYCLES, 4800000: idle cycles after the last written byte before running status is forgotten (300 ms at 16 MHz). 0 disables the timeout.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- ev_valid  in  1  event offered
- ev_ready  out  1  block can accept an event this cycle
- ev_status  in  8  MIDI status byte
- ev_data1  in  7  first data byte payload
- ev_data2  in  7  second data byte payload
- tx_we  out  1  byte write request to UART, held until accepted
- tx_data  out  8  byte to transmit
- tx_busy  in  1  UART stall; a write is accepted in any cycle with tx_we=1 and tx_busy=0
- drop  out  1  one-cycle pulse: event discarded because ev_status[7]=0
- idle  out  1  IDLE state and no event pending

Behaviour:
- Clock and reset:
  - One clock, clk. resetn is asynchronous and active-low; all flops clear immediately on assertion.
  - Reset values: state=IDLE, ev_ready=1, tx_we=0, tx_data=0, drop=0, idle=1, last_status invalid, timeout counter=0.
- Handshake: an event is accepted when ev_valid && ev_ready; ev_status/ev_data1/ev_data2 are latched on that edge.
- ev_ready:
  - ev_ready=1 only in IDLE, so one event is in flight at a time.
  - ev_ready returns high the cycle after the last byte of the event is accepted.
- Message length from ev_status:
  - 8x,9x,Ax,Bx,Ex: 3 bytes.
  - Cx,Dx: 2 bytes.
  - F1,F3: 2 bytes.
  - F2: 3 bytes.
  - F0,F4-F7: 1 byte.
  - F8-FF: 1 byte.
- Data bytes are sent as {1'b0, ev_dataN}.
- States:
  - IDLE:
    - On accept with ev_status[7]=0: pulse drop, stay in IDLE, send nothing.
    - On accept otherwise: go to S_STATUS, or to S_D1 when the status byte is suppressed.
  - S_STATUS: tx_we=1, tx_data=status. On write accepted: go to S_D1 if length>1, else IDLE.
  - S_D1: tx_we=1, tx_data=data1. On write accepted: go to S_D2 if length=3, else IDLE.
  - S_D2: tx_we=1, tx_data=data2. On write accepted: go to IDLE.
- tx_we/tx_data are registered and stable while tx_we=1 and tx_busy=1; tx_we never drops before acceptance.
- Back-to-back bytes: the next byte is presented on the cycle after acceptance.
- Running status:
  - last_status (8 bits + valid) is set whenever a channel status byte (80-EF) is written.
  - A channel event's status byte is suppressed iff RUNNING_STATUS=1, last_status valid, and ev_status==last_status.
  - F0-F7 (written or not) invalidates last_status.
  - F8-FF never touches last_status or the timeout counter. Real-time bytes may be sent between running-status messages.
- Timeout counter (32-bit, saturating):
  - Clears on each accepted non-real-time byte; otherwise increments.
  - When the counter reaches RS_TIMEOUT_CYCLES (nonzero), last_status becomes invalid.
  - Expiry and acceptance in the same cycle: expiry wins and the status byte is sent.
- Reset mid-message aborts the message immediately: tx_we=0, and the partial message is not resumed.

Decomposition:
- Shared package midi_pkg:
  - status nibble constants (NOTE_OFF=8, NOTE_ON=9, POLY_AT=A, CC=B, PROG=C, CH_AT=D, PITCH=E, SYS=F)
  - message-length function msg_len(status) returning 1..3
  - is_realtime(status) predicate
- No sub-module. Length decode and running-status comparison are combinational in-module.

Test Plan:
- Note on with UART idle (tx_busy=0): event 90/3C/64 -> bytes 90,3C,64 on consecutive cycles; ev_ready low 3 cycles.
- Running status:
  - 90/3C/64 then 90/40/00 -> bytes 90,3C,64,40,00.
  - Same with RUNNING_STATUS=0 -> 90 is repeated.
- Status change and system common:
  - 90/3C/64, C0/05, 90/3C/00 -> 90,3C,64,C0,05,90,3C,00.
  - An F2 event in between forces 90 to be re-sent.
- Real-time interleave: 90/3C/64, F8, 90/3E/64 -> 90,3C,64,F8,3E,64 (running status kept).
- Backpressure and timeout:
  - tx_busy=1 for 50 cycles mid-message -> tx_we/tx_data held at 3C, no byte lost.
  - With RS_TIMEOUT_CYCLES=10, a repeat 90 event after 20 idle cycles -> 90 re-sent.
- Bad status and reset:
  - ev_status=3C -> drop pulse, no tx_we.
  - resetn low during S_D1 -> tx_we=0 asynchronously; next 90 event sends full 90,xx,yy.
